// File: rtl/multi_score_tracker.sv
// ============================================================================
// multi_score_tracker
//   Per-player scores, a persistent owned high score and an IDLE/PLAY/OVER game FSM.
//   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_score_tracker #(
    parameter int WIDTH     = 7,
    parameter int MAX_SCORE = 100,
    parameter int STEP      = 1,
    parameter int PLAYERS   = 2,
    localparam int IDW      = $clog2(PLAYERS)
) (
    input  logic                     clk,
    input  logic                     nRst,
    input  logic                     start,
    input  logic [PLAYERS-1:0]       goodColl,
    input  logic [PLAYERS-1:0]       badColl,
    output logic [PLAYERS*WIDTH-1:0] currScore,
    output logic [WIDTH-1:0]         highScore,
    output logic [IDW-1:0]           highOwner,
    output logic [1:0]               state,
    output logic                     gameOver,
    output logic                     won,
    output logic [IDW-1:0]           endPlayer,
    output logic                     newHigh
);

    localparam int SUMW = WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        OVER = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] score_q [PLAYERS];
    logic [WIDTH-1:0] score_d [PLAYERS];
    logic [WIDTH-1:0] high_q, high_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic [IDW-1:0]   end_q, end_d;
    logic             won_q, won_d;
    logic             game_over_q, game_over_d;
    logic             new_high_q, new_high_d;

    logic [SUMW-1:0]  sum;
    logic [WIDTH-1:0] max_v;
    logic [IDW-1:0]   max_id;
    logic [IDW-1:0]   bad_id;
    logic [IDW-1:0]   hit_id;
    logic             hit;

    always_comb begin
        state_d     = state_q;
        high_d      = high_q;
        owner_d     = owner_q;
        end_d       = end_q;
        won_d       = won_q;
        new_high_d  = 1'b0;
        sum         = '0;
        max_v       = '0;
        max_id      = '0;
        bad_id      = '0;
        hit_id      = '0;
        hit         = 1'b0;
        for (int i = 0; i < PLAYERS; i++) begin
            score_d[i] = score_q[i];
        end
        // Scanning downward leaves the lowest matching index as the winner.
        for (int i = PLAYERS - 1; i >= 0; i--) begin
            if (badColl[i]) begin
                bad_id = IDW'(i);
            end
        end

        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d = PLAY;
                    won_d   = 1'b0;
                    end_d   = '0;
                    for (int i = 0; i < PLAYERS; i++) begin
                        score_d[i] = '0;
                    end
                end
            end
            PLAY: begin
                if (|badColl) begin
                    state_d = OVER;
                    won_d   = 1'b0;
                    end_d   = bad_id;
                end else begin
                    for (int i = 0; i < PLAYERS; i++) begin
                        if (goodColl[i]) begin
                            sum = {1'b0, score_q[i]} + SUMW'(STEP);
                            score_d[i] = (sum >= SUMW'(MAX_SCORE)) ? WIDTH'(MAX_SCORE)
                                                                   : sum[WIDTH-1:0];
                        end
                    end
                    for (int i = PLAYERS - 1; i >= 0; i--) begin
                        if (score_d[i] == WIDTH'(MAX_SCORE)) begin
                            hit    = 1'b1;
                            hit_id = IDW'(i);
                        end
                    end
                    if (hit) begin
                        state_d = OVER;
                        won_d   = 1'b1;
                        end_d   = hit_id;
                    end
                end
                for (int i = 0; i < PLAYERS; i++) begin
                    if (score_d[i] > max_v) begin
                        max_v = score_d[i];
                    end
                end
                for (int i = PLAYERS - 1; i >= 0; i--) begin
                    if (score_d[i] == max_v) begin
                        max_id = IDW'(i);
                    end
                end
                // Strictly greater: a tie keeps the earlier owner.
                if (max_v > high_q) begin
                    high_d     = max_v;
                    owner_d    = max_id;
                    new_high_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        game_over_d = (state_q == PLAY) && (state_d == OVER);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= IDLE;
            high_q      <= '0;
            owner_q     <= '0;
            end_q       <= '0;
            won_q       <= 1'b0;
            game_over_q <= 1'b0;
            new_high_q  <= 1'b0;
            for (int i = 0; i < PLAYERS; i++) begin
                score_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            high_q      <= high_d;
            owner_q     <= owner_d;
            end_q       <= end_d;
            won_q       <= won_d;
            game_over_q <= game_over_d;
            new_high_q  <= new_high_d;
            for (int i = 0; i < PLAYERS; i++) begin
                score_q[i] <= score_d[i];
            end
        end
    end

    for (genvar g = 0; g < PLAYERS; g++) begin : g_score_out
        assign currScore[g*WIDTH +: WIDTH] = score_q[g];
    end

    assign highScore = high_q;
    assign highOwner = owner_q;
    assign state     = state_q;
    assign gameOver  = game_over_q;
    assign won       = won_q;
    assign endPlayer = end_q;
    assign newHigh   = new_high_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_score_tracker.sv
// ============================================================================
// tb_multi_score_tracker
//   Directed bench: default instance (MAX 100, STEP 1) and a small instance (MAX 10, STEP 3).
//   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_score_tracker;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [1:0]  good_a = '0, bad_a = '0, good_b = '0, bad_b = '0;
    logic [13:0] cs_a, cs_b;
    logic [6:0]  hs_a, hs_b;
    logic        ho_a, ho_b, go_a, go_b, won_a, won_b, ep_a, ep_b, nh_a, nh_b;
    logic [1:0]  st_a, st_b;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          nh_cnt;

    always #5 clk = ~clk;

    multi_score_tracker u_a (
        .clk(clk), .nRst(nRst), .start(start_a), .goodColl(good_a), .badColl(bad_a),
        .currScore(cs_a), .highScore(hs_a), .highOwner(ho_a), .state(st_a),
        .gameOver(go_a), .won(won_a), .endPlayer(ep_a), .newHigh(nh_a)
    );

    multi_score_tracker #(.WIDTH(7), .MAX_SCORE(10), .STEP(3), .PLAYERS(2)) u_b (
        .clk(clk), .nRst(nRst), .start(start_b), .goodColl(good_b), .badColl(bad_b),
        .currScore(cs_b), .highScore(hs_b), .highOwner(ho_b), .state(st_b),
        .gameOver(go_b), .won(won_b), .endPlayer(ep_b), .newHigh(nh_b)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        #12;
        n_cmp++; if (st_a !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %0d want 0", st_a); end
        n_cmp++; if (cs_a !== 14'd0) begin n_fail++; $display("FAIL reset_scores: got %0h want 0", cs_a); end
        n_cmp++; if ({hs_a, ho_a, ep_a, won_a, go_a, nh_a} !== 12'd0) begin n_fail++;
            $display("FAIL reset_misc: got hs=%0d ho=%0d ep=%0d won=%0d go=%0d nh=%0d want all 0", hs_a, ho_a, ep_a, won_a, go_a, nh_a); end
        @(negedge clk);
        nRst = 1'b1;
        cyc();
        good_a = 2'b11; bad_a = 2'b00;
        cyc();
        cyc();
        n_cmp++; if (cs_a !== 14'd0 || st_a !== 2'b00) begin n_fail++;
            $display("FAIL idle_ignores_coll: got cs=%0h st=%0d want 0/0", cs_a, st_a); end
        good_a = 2'b00;
    endtask

    task automatic test_score_p0();
        start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        n_cmp++; if (st_a !== 2'b01) begin n_fail++; $display("FAIL start_play: got %0d want 1", st_a); end
        good_a = 2'b01;
        nh_cnt = 0;
        repeat (3) begin
            cyc();
            if (nh_a === 1'b1) nh_cnt++;
        end
        good_a = 2'b00;
        n_cmp++; if (cs_a[6:0] !== 7'd3 || cs_a[13:7] !== 7'd0) begin n_fail++;
            $display("FAIL p0_score: got p0=%0d p1=%0d want 3/0", cs_a[6:0], cs_a[13:7]); end
        n_cmp++; if (hs_a !== 7'd3 || ho_a !== 1'b0) begin n_fail++;
            $display("FAIL p0_high: got hs=%0d ho=%0d want 3/0", hs_a, ho_a); end
        n_cmp++; if (nh_cnt !== 3) begin n_fail++; $display("FAIL p0_newhigh_count: got %0d want 3", nh_cnt); end
        cyc();
        n_cmp++; if (nh_a !== 1'b0) begin n_fail++; $display("FAIL newhigh_drop: got %0d want 0", nh_a); end
    endtask

    task automatic test_owner_and_bad();
        good_a = 2'b10;
        repeat (3) cyc();
        n_cmp++; if (hs_a !== 7'd3 || ho_a !== 1'b0) begin n_fail++;
            $display("FAIL tie_keeps_owner: got hs=%0d ho=%0d want 3/0", hs_a, ho_a); end
        cyc();
        n_cmp++; if (hs_a !== 7'd4 || ho_a !== 1'b1 || nh_a !== 1'b1) begin n_fail++;
            $display("FAIL owner_p1: got hs=%0d ho=%0d nh=%0d want 4/1/1", hs_a, ho_a, nh_a); end
        cyc();
        n_cmp++; if (cs_a[13:7] !== 7'd5 || hs_a !== 7'd5) begin n_fail++;
            $display("FAIL p1_five: got p1=%0d hs=%0d want 5/5", cs_a[13:7], hs_a); end
        bad_a = 2'b10;
        cyc();
        good_a = 2'b00; bad_a = 2'b00;
        n_cmp++; if (st_a !== 2'b10 || won_a !== 1'b0 || ep_a !== 1'b1 || go_a !== 1'b1) begin n_fail++;
            $display("FAIL bad_end: got st=%0d won=%0d ep=%0d go=%0d want 2/0/1/1", st_a, won_a, ep_a, go_a); end
        n_cmp++; if (cs_a[13:7] !== 7'd5 || cs_a[6:0] !== 7'd3) begin n_fail++;
            $display("FAIL bad_scores: got p0=%0d p1=%0d want 3/5", cs_a[6:0], cs_a[13:7]); end
        cyc();
        n_cmp++; if (go_a !== 1'b0 || st_a !== 2'b10) begin n_fail++;
            $display("FAIL gameover_pulse: got go=%0d st=%0d want 0/2", go_a, st_a); end
        good_a = 2'b11; bad_a = 2'b11;
        cyc();
        cyc();
        good_a = 2'b00; bad_a = 2'b00;
        n_cmp++; if (cs_a !== {7'd5, 7'd3} || st_a !== 2'b10 || hs_a !== 7'd5 || ep_a !== 1'b1 || go_a !== 1'b0) begin n_fail++;
            $display("FAIL over_ignores: got cs=%0h st=%0d hs=%0d ep=%0d go=%0d want 283/2/5/1/0", cs_a, st_a, hs_a, ep_a, go_a); end
    endtask

    task automatic test_restart();
        start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        n_cmp++; if (st_a !== 2'b01 || cs_a !== 14'd0 || won_a !== 1'b0 || ep_a !== 1'b0) begin n_fail++;
            $display("FAIL restart: got st=%0d cs=%0h won=%0d ep=%0d want 1/0/0/0", st_a, cs_a, won_a, ep_a); end
        n_cmp++; if (hs_a !== 7'd5 || ho_a !== 1'b1) begin n_fail++;
            $display("FAIL restart_high: got hs=%0d ho=%0d want 5/1", hs_a, ho_a); end
    endtask

    task automatic test_saturate();
        start_b = 1'b1;
        cyc();
        start_b = 1'b0;
        good_b = 2'b01;
        repeat (3) cyc();
        good_b = 2'b10;
        repeat (3) cyc();
        n_cmp++; if (cs_b !== {7'd9, 7'd9} || st_b !== 2'b01 || hs_b !== 7'd9 || ho_b !== 1'b0) begin n_fail++;
            $display("FAIL pre_sat: got cs=%0h st=%0d hs=%0d ho=%0d want 489/1/9/0", cs_b, st_b, hs_b, ho_b); end
        good_b = 2'b11;
        cyc();
        good_b = 2'b00;
        n_cmp++; if (cs_b !== {7'd10, 7'd10}) begin n_fail++;
            $display("FAIL saturate: got p0=%0d p1=%0d want 10/10", cs_b[6:0], cs_b[13:7]); end
        n_cmp++; if (st_b !== 2'b10 || won_b !== 1'b1 || ep_b !== 1'b0 || go_b !== 1'b1) begin n_fail++;
            $display("FAIL win_end: got st=%0d won=%0d ep=%0d go=%0d want 2/1/0/1", st_b, won_b, ep_b, go_b); end
        n_cmp++; if (hs_b !== 7'd10 || ho_b !== 1'b0 || nh_b !== 1'b1) begin n_fail++;
            $display("FAIL win_high: got hs=%0d ho=%0d nh=%0d want 10/0/1", hs_b, ho_b, nh_b); end
        start_b = 1'b1;
        cyc();
        start_b = 1'b0;
        n_cmp++; if (st_b !== 2'b01 || cs_b !== 14'd0 || hs_b !== 7'd10) begin n_fail++;
            $display("FAIL sat_restart: got st=%0d cs=%0h hs=%0d want 1/0/10", st_b, cs_b, hs_b); end
    endtask

    task automatic test_bad_beats_win();
        good_b = 2'b01;
        repeat (3) cyc();
        bad_b = 2'b01;
        cyc();
        good_b = 2'b00; bad_b = 2'b00;
        n_cmp++; if (st_b !== 2'b10 || won_b !== 1'b0 || ep_b !== 1'b0 || cs_b !== {7'd0, 7'd9}) begin n_fail++;
            $display("FAIL bad_beats_win: got st=%0d won=%0d ep=%0d cs=%0h want 2/0/0/9", st_b, won_b, ep_b, cs_b); end
    endtask

    task automatic test_async_reset();
        good_a = 2'b01;
        repeat (7) cyc();
        good_a = 2'b00;
        n_cmp++; if (hs_a !== 7'd7 || st_a !== 2'b01) begin n_fail++;
            $display("FAIL pre_reset: got hs=%0d st=%0d want 7/1", hs_a, st_a); end
        nRst = 1'b0;
        #2;
        n_cmp++; if (st_a !== 2'b00 || cs_a !== 14'd0 || hs_a !== 7'd0 || ho_a !== 1'b0) begin n_fail++;
            $display("FAIL async_reset_a: got st=%0d cs=%0h hs=%0d ho=%0d want all 0", st_a, cs_a, hs_a, ho_a); end
        n_cmp++; if (st_b !== 2'b00 || hs_b !== 7'd0 || won_b !== 1'b0 || ep_b !== 1'b0 || cs_b !== 14'd0) begin n_fail++;
            $display("FAIL async_reset_b: got st=%0d hs=%0d won=%0d ep=%0d cs=%0h want all 0", st_b, hs_b, won_b, ep_b, cs_b); end
        @(negedge clk);
        nRst = 1'b1;
        cyc();
        start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        n_cmp++; if (st_a !== 2'b01) begin n_fail++; $display("FAIL start_after_reset: got %0d want 1", st_a); end
    endtask

    initial begin
        test_reset();
        test_score_p0();
        test_owner_and_bad();
        test_restart();
        test_saturate();
        test_bad_beats_win();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
